oled_iic_arb: RTL

//   Sequencing arbiter that shares the single IIC write master between the OLED init, clear and char engines.

---
 rtl/oled_iic_arb.sv | 104 ++++++++++
 1 files changed

// File: rtl/oled_iic_arb.sv
// Fixed-priority (init > clear > char) arbiter that shares one IIC write master
// between the OLED engines; one 24-bit transfer in flight, bounded by a watchdog.
module oled_iic_arb #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        i_init_req,
    input  logic [23:0] i_init_data,
    output logic        o_init_ack,
    input  logic        i_clear_req,
    input  logic [23:0] i_clear_data,
    output logic        o_clear_ack,
    input  logic        i_char_req,
    input  logic [23:0] i_char_data,
    output logic        o_char_ack,
    output logic        o_iic_req,
    output logic [23:0] o_iic_data,
    input  logic        i_iic_done,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [1:0] G_NONE  = 2'd0;
    localparam logic [1:0] G_INIT  = 2'd1;
    localparam logic [1:0] G_CLEAR = 2'd2;
    localparam logic [1:0] G_CHAR  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             expired;
    logic             finish;

    // A done pulse in the expiry cycle wins, so expiry only counts without done.
    always_comb begin
        any_req = i_init_req | i_clear_req | i_char_req;
        expired = (state == S_WAIT) && (cnt == CNT_LAST) && !i_iic_done;
        finish  = (((state == S_ISSUE) || (state == S_WAIT)) && i_iic_done) || expired;
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            o_iic_req   <= 1'b0;
            o_iic_data  <= '0;
            o_grant     <= G_NONE;
            o_init_ack  <= 1'b0;
            o_clear_ack <= 1'b0;
            o_char_ack  <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_iic_req   <= 1'b0;
            o_init_ack  <= finish && (o_grant == G_INIT);
            o_clear_ack <= finish && (o_grant == G_CLEAR);
            o_char_ack  <= finish && (o_grant == G_CHAR);
            o_timeout   <= expired;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        o_iic_req <= 1'b1;
                        state     <= S_ISSUE;
                    end
                    if (i_init_req) begin
                        o_grant    <= G_INIT;
                        o_iic_data <= i_init_data;
                    end else if (i_clear_req) begin
                        o_grant    <= G_CLEAR;
                        o_iic_data <= i_clear_data;
                    end else if (i_char_req) begin
                        o_grant    <= G_CHAR;
                        o_iic_data <= i_char_data;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= i_iic_done ? S_ACK : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    // o_iic_data deliberately keeps the last word
                    o_grant <= G_NONE;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
